// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence-detector family.
package seq_det_pkg;

    // Controller state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Pattern held in the configuration register before the first run.
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_match_window.sv
// Serial match window: PAT_W-bit history of the bit stream, a saturating
// fill counter and the comparator that flags a completed pattern.
module seq_match_window
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_bit,
    input  logic             bit_en,
    input  logic             clr,
    input  logic             overlap,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  window_reg;
    logic [PAT_W-1:0]  window_next;
    logic [FILL_W-1:0] fill_reg;
    logic [FILL_W-1:0] fill_next;

    // Next window/fill values and the hit decision for the bit being consumed.
    // A clear in the same cycle suppresses the hit so an abort never strobes.
    always_comb begin
        window_next = {window_reg[PAT_W-2:0], serial_bit};
        fill_next   = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FILL_W'(1);
        hit         = bit_en & ~clr & (fill_next == FILL_FULL) & (window_next == pattern);
    end

    // Window and fill registers; non-overlap mode restarts the fill after a hit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window_reg <= '0;
            fill_reg   <= '0;
        end else if (clr) begin
            window_reg <= '0;
            fill_reg   <= '0;
        end else if (bit_en) begin
            window_reg <= window_next;
            fill_reg   <= (hit && !overlap) ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/seq_stream_ctrl.sv
// Word-to-serial stream controller: accepts words over valid/ready, shifts
// them MSB-first into the match window, counts hits and stops at a limit.
module seq_stream_ctrl
    import seq_det_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
    input  logic [CNT_W-1:0]  cfg_limit,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [PAT_W-1:0]  pattern_reg;
    logic              overlap_reg;
    logic [CNT_W-1:0]  limit_reg;
    logic              in_ready_reg;
    logic              bit_valid_reg;
    logic              match_pulse_reg;
    logic              busy_reg;
    logic              done_reg;

    logic              start_run;
    logic              win_clr;
    logic              win_bit_en;
    logic              hit;
    logic [CNT_W-1:0]  count_next;
    logic              limit_reached;

    // Run start, window control and hit bookkeeping derived from current state.
    always_comb begin
        start_run     = ((state_reg == IDLE) || (state_reg == DONE)) && start && !abort;
        win_clr       = abort || start_run;
        win_bit_en    = (state_reg == SHIFT);
        count_next    = (count_reg == '1) ? count_reg : count_reg + CNT_W'(1);
        limit_reached = hit && (limit_reg != '0) && (count_next == limit_reg);
    end

    seq_match_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk        (clk),
        .reset_n    (reset_n),
        .serial_bit (shift_reg[DATA_W-1]),
        .bit_en     (win_bit_en),
        .clr        (win_clr),
        .overlap    (overlap_reg),
        .pattern    (pattern_reg),
        .hit        (hit)
    );

    // Main FSM with registered handshake, serial and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            idx_reg         <= '0;
            count_reg       <= '0;
            pattern_reg     <= PAT_W'(DEFAULT_PATTERN);
            overlap_reg     <= 1'b0;
            limit_reg       <= '0;
            in_ready_reg    <= 1'b0;
            bit_valid_reg   <= 1'b0;
            match_pulse_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            match_pulse_reg <= 1'b0;
            if (abort) begin
                // Count is held so software can read how far the run got.
                state_reg     <= IDLE;
                in_ready_reg  <= 1'b0;
                bit_valid_reg <= 1'b0;
                busy_reg      <= 1'b0;
                done_reg      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE, DONE: begin
                        if (start) begin
                            state_reg    <= ARM;
                            pattern_reg  <= cfg_pattern;
                            overlap_reg  <= cfg_overlap;
                            limit_reg    <= cfg_limit;
                            count_reg    <= '0;
                            in_ready_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                            done_reg     <= 1'b0;
                        end
                    end
                    ARM: begin
                        if (in_valid && in_ready_reg) begin
                            state_reg     <= SHIFT;
                            shift_reg     <= in_data;
                            idx_reg       <= IDX_W'(DATA_W - 1);
                            in_ready_reg  <= 1'b0;
                            bit_valid_reg <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                        idx_reg   <= idx_reg - IDX_W'(1);
                        if (hit) begin
                            match_pulse_reg <= 1'b1;
                            count_reg       <= count_next;
                        end
                        if (limit_reached) begin
                            // Remaining bits of the current word are dropped.
                            state_reg     <= DONE;
                            bit_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                        end else if (idx_reg == '0) begin
                            state_reg     <= ARM;
                            bit_valid_reg <= 1'b0;
                            in_ready_reg  <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign in_ready    = in_ready_reg;
    assign bit_out     = shift_reg[DATA_W-1] & bit_valid_reg;
    assign bit_valid   = bit_valid_reg;
    assign match_pulse = match_pulse_reg;
    assign match_count = count_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Scoreboard bench for seq_stream_ctrl: stimulus pushes expected serial bits
// and expected hit events; a negedge monitor pops and compares them.
module tb_seq_stream_ctrl;

    localparam int DATA_W = 8;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [PAT_W-1:0]  cfg_pattern = '0;
    logic              cfg_overlap = 1'b0;
    logic [CNT_W-1:0]  cfg_limit = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              bit_out;
    logic              bit_valid;
    logic              match_pulse;
    logic [CNT_W-1:0]  match_count;
    logic              busy;
    logic              done;

    seq_stream_ctrl #(
        .DATA_W (DATA_W),
        .PAT_W  (PAT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .cfg_limit   (cfg_limit),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .match_pulse (match_pulse),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               bitno;
        logic [CNT_W-1:0] cnt;
    } hit_t;

    logic  bitq[$];
    hit_t  hitq[$];
    int    checks = 0;
    int    failures = 0;
    int    bits_issued = 0;
    int    bits_seen = 0;
    int    exp_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every DUT bit and every hit strobe must match the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (match_pulse) begin
                if (hitq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: got pulse count=%0d expected none", match_count);
                end else begin
                    hit_t e;
                    e = hitq.pop_front();
                    check("hit_position", bits_seen, e.bitno);
                    check("hit_count", match_count, e.cnt);
                end
            end
            if (bit_valid) begin
                if (bitq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bit: got bit %0b expected none", bit_out);
                end else begin
                    logic b;
                    b = bitq.pop_front();
                    check("serial_bit", bit_out, b);
                end
                bits_seen++;
            end
        end
    end

    // Begin a run; cfg is scrambled right after start to show it is latched.
    task automatic start_run(input logic [PAT_W-1:0] pat, input logic ov,
                             input logic [CNT_W-1:0] lim, input logic via_abort);
        if (via_abort) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
        end
        cfg_pattern = pat;
        cfg_overlap = ov;
        cfg_limit   = lim;
        start       = 1'b1;
        step();
        start       = 1'b0;
        cfg_pattern = ~pat;
        cfg_overlap = ~ov;
        cfg_limit   = 8'd3;
        exp_count   = 0;
        check("start_ready", in_ready, 1);
        check("start_busy_done", {busy, done}, 2'b10);
        check("start_count", match_count, 0);
    endtask

    // mode 0: full word, 1: limit stop after nbits, 2: abort in cycle nbits,
    // 3: reset in cycle nbits. mask[j] = hit completes on data bit j.
    task automatic send_word(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] mask,
                             input int nbits, input int mode);
        int cyc;
        for (int i = 1; i <= nbits; i++) begin
            bitq.push_back(w[DATA_W-i]);
            bits_issued++;
            if (mask[DATA_W-i] && !(mode >= 2 && i == nbits)) begin
                hit_t e;
                exp_count = (exp_count == 255) ? 255 : exp_count + 1;
                e.bitno = bits_issued;
                e.cnt   = CNT_W'(exp_count);
                hitq.push_back(e);
            end
        end
        check("ready_before_word", in_ready, 1);
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        if (mode == 0) begin
            cyc = 1;
            while (!in_ready && cyc < 20) begin
                step();
                cyc++;
            end
            check("ready_latency", cyc, DATA_W + 1);
        end else if (mode == 1) begin
            repeat (nbits) step();
            check("limit_done", {done, busy, bit_valid, in_ready}, 4'b1000);
        end else if (mode == 2) begin
            repeat (nbits - 1) step();
            abort = 1'b1;
            step();
            abort = 1'b0;
            check("abort_idle", {busy, done, bit_valid, in_ready, match_pulse}, 5'b0);
            check("abort_count_held", match_count, exp_count);
        end else begin
            repeat (nbits - 1) step();
            @(negedge clk);
            #1;
            reset_n = 1'b0;
            #1;
            check("reset_mid_word_outputs",
                  {in_ready, bit_out, bit_valid, match_pulse, busy, done, match_count}, 0);
            repeat (2) @(posedge clk);
            #1;
            reset_n = 1'b1;
            exp_count = 0;
        end
    endtask

    task automatic drain(input string name);
        repeat (3) step();
        check(name, bitq.size() + hitq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {in_ready, bit_out, bit_valid, match_pulse, busy, done, match_count}, 0);
        reset_n = 1'b1;
        step();
        check("idle_after_reset", {in_ready, busy, done}, 0);

        // Non-overlap 1101 on 0xDA: one hit after bit 4.
        start_run(4'b1101, 1'b0, 8'd0, 1'b0);
        send_word(8'hDA, 8'h10, 8, 0);
        drain("drain_nonoverlap");
        check("count_nonoverlap", match_count, 1);

        // Overlap: hits after bits 4 and 7.
        start_run(4'b1101, 1'b1, 8'd0, 1'b1);
        send_word(8'hDA, 8'h12, 8, 0);
        drain("drain_overlap");
        check("count_overlap", match_count, 2);

        // Limit 1: DONE after bit 4, bits 5-8 never presented.
        start_run(4'b1101, 1'b1, 8'd1, 1'b1);
        send_word(8'hDA, 8'h10, 4, 1);
        repeat (6) step();
        check("done_held", {done, busy}, 2'b10);
        check("done_count_held", match_count, 1);

        // Restart from DONE; 0x01 then 0xA0 completes 1101 on bit 3 of word 2.
        start_run(4'b1101, 1'b0, 8'd0, 1'b0);
        send_word(8'h01, 8'h00, 8, 0);
        send_word(8'hA0, 8'h20, 8, 0);
        drain("drain_boundary");
        check("count_boundary", match_count, 1);

        // Idle ARM for 10 cycles, then a word; then abort in cycle 3 of 0xFF.
        start_run(4'b1101, 1'b1, 8'd0, 1'b1);
        repeat (10) step();
        check("arm_wait_ready", {in_ready, bit_valid, busy}, 3'b101);
        send_word(8'hDA, 8'h12, 8, 0);
        send_word(8'hFF, 8'h00, 3, 2);
        drain("drain_abort3");

        // Simultaneous start and abort stays in IDLE.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", {in_ready, busy, done}, 0);
        check("start_abort_count", match_count, 2);

        // Abort on the completing bit 8 of 0xDD: no strobe, count stays 1.
        start_run(4'b1101, 1'b1, 8'd0, 1'b0);
        send_word(8'hDD, 8'h11, 8, 2);
        drain("drain_abort8");

        // Unlimited run saturates the counter at 255.
        start_run(4'b1111, 1'b1, 8'd0, 1'b1);
        send_word(8'hFF, 8'h1F, 8, 0);
        for (int k = 0; k < 33; k++) send_word(8'hFF, 8'hFF, 8, 0);
        drain("drain_saturate");
        check("count_saturated", match_count, 255);

        // Reset mid-word in cycle 3.
        start_run(4'b1101, 1'b0, 8'd0, 1'b1);
        send_word(8'hDA, 8'h10, 3, 3);
        drain("drain_reset");
        check("after_reset_outputs",
              {in_ready, bit_out, bit_valid, match_pulse, busy, done, match_count}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
